// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register slice.
package pipe_pkg;

    // Occupancy of the two-entry skid stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // EX/MEM payload: alu_result 32 + write_data 32 + write_reg 5 + upper 1
    localparam int EXMEM_DATA_W = 70;
    // EX/MEM control: reg_write, mem_to_reg, mem_write
    localparam int EXMEM_CTRL_W = 3;
    localparam int STALL_CNT_W  = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_ONE = 1;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == STALL_CNT_MAX) ? v : v + STALL_CNT_ONE;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flag, control and payload captured together.
// Clear wins over load; clear zeroes valid and control but leaves the payload.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Slot register: reset clears everything, clear squashes, load captures all fields at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (EX/MEM style) with optional two-entry skid
// buffer, flush, and a saturating downstream-stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   w_in_ready;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_out_valid;
    logic [CTRL_W-1:0]      w_out_ctrl;
    logic [DATA_W-1:0]      w_out_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = w_out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       r_state;
            pipe_state_t       w_state_nxt;
            logic              r_in_ready;
            logic              w_load0;
            logic              w_clear0;
            logic              w_load1;
            logic              w_clear1;
            logic              w_sel_skid;
            logic              w_skid_valid;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;
            logic [CTRL_W-1:0] w_e0_ctrl;
            logic [DATA_W-1:0] w_e0_data;

            // State register; in_ready is registered alongside so it never depends on out_ready
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != TWO);
                end
            end

            // Next-state: flush empties the stage regardless of traffic
            always_comb begin
                w_state_nxt = r_state;
                if (flush) begin
                    w_state_nxt = EMPTY;
                end else begin
                    case (r_state)
                        EMPTY: if (w_in_xfer) w_state_nxt = ONE;
                        ONE: begin
                            if (w_in_xfer && !w_out_xfer)      w_state_nxt = TWO;
                            else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
                        end
                        TWO:     if (w_out_xfer) w_state_nxt = ONE;
                        default: w_state_nxt = EMPTY;
                    endcase
                end
            end

            // Entry controls: output slot refills from input or, when draining TWO, from the skid slot
            always_comb begin
                w_load0    = 1'b0;
                w_clear0   = 1'b0;
                w_load1    = 1'b0;
                w_clear1   = 1'b0;
                w_sel_skid = 1'b0;
                if (flush) begin
                    w_clear0 = 1'b1;
                    w_clear1 = 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: w_load0 = w_in_xfer;
                        ONE: begin
                            if (w_in_xfer && w_out_xfer) w_load0  = 1'b1;
                            else if (w_in_xfer)          w_load1  = 1'b1;
                            else if (w_out_xfer)         w_clear0 = 1'b1;
                        end
                        TWO: begin
                            if (w_out_xfer) begin
                                w_load0    = w_skid_valid;
                                w_sel_skid = 1'b1;
                                w_clear1   = 1'b1;
                            end
                        end
                        default: begin
                            w_clear0 = 1'b1;
                            w_clear1 = 1'b1;
                        end
                    endcase
                end
            end

            assign w_e0_ctrl  = w_sel_skid ? w_skid_ctrl : in_ctrl;
            assign w_e0_data  = w_sel_skid ? w_skid_data : in_data;
            assign w_in_ready = r_in_ready;

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out_entry (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load0),
                .i_clear (w_clear0),
                .i_ctrl  (w_e0_ctrl),
                .i_data  (w_e0_data),
                .o_valid (w_out_valid),
                .o_ctrl  (w_out_ctrl),
                .o_data  (w_out_data)
            );

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid_entry (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load1),
                .i_clear (w_clear1),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end else begin : g_single
            logic w_clear;

            // Single slot accepts when it is empty or being drained this cycle
            assign w_in_ready = out_ready | ~w_out_valid;
            assign w_clear    = flush | (w_out_xfer & ~w_in_xfer);

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out_entry (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_in_xfer),
                .i_clear (w_clear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_out_valid),
                .o_ctrl  (w_out_ctrl),
                .o_data  (w_out_data)
            );
        end
    endgenerate

    // Count cycles where downstream holds off a valid output, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // A bubble must never present write enables downstream
    assign out_ctrl  = w_out_valid ? w_out_ctrl : '0;
    assign out_data  = w_out_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each checked
// against an in-order FIFO reference of bounded capacity (1 or 2 entries).
module tb_pipe_stage_reg;

    localparam int DW = 70;
    localparam int CW = 3;
    localparam int IW = DW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid_a  [2];
    logic          in_ready_a  [2];
    logic [CW-1:0] in_ctrl_a   [2];
    logic [DW-1:0] in_data_a   [2];
    logic          out_valid_a [2];
    logic          out_ready_a [2];
    logic [CW-1:0] out_ctrl_a  [2];
    logic [DW-1:0] out_data_a  [2];
    logic          flush_a     [2];
    logic [15:0]   stall_a     [2];

    int errors = 0;
    int checks = 0;

    // Reference: ring FIFO per instance holding accepted, not yet consumed words
    logic [IW-1:0] rbuf   [2][4];
    int            rhead  [2];
    int            rcnt   [2];
    bit            pend   [2];
    int            m_stall[2];
    logic [DW-1:0] last_d [2];
    int            held;
    logic [IW-1:0] front;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(k)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[k]),
            .in_ready  (in_ready_a[k]),
            .in_ctrl   (in_ctrl_a[k]),
            .in_data   (in_data_a[k]),
            .out_valid (out_valid_a[k]),
            .out_ready (out_ready_a[k]),
            .out_ctrl  (out_ctrl_a[k]),
            .out_data  (out_data_a[k]),
            .flush     (flush_a[k]),
            .stall_cnt (stall_a[k])
        );
    end

    task automatic chk(input string name, input int k, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", name, k, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [IW-1:0] w);
        rbuf[k][(rhead[k] + rcnt[k]) % 4] = w;
        rcnt[k]++;
        pend[k] = 1'b1;
    endtask

    // One cycle of stimulus on instance k; a word is expected downstream only if it is accepted and not flushed
    task automatic drive_a(input int k, input logic v, input logic [IW-1:0] w, input logic ordy,
                           input logic fl, output bit acc);
        @(posedge clk);
        #1;
        in_valid_a[k]              = v;
        {in_ctrl_a[k], in_data_a[k]} = w;
        out_ready_a[k]             = ordy;
        flush_a[k]                 = fl;
        #1;
        acc = v && in_ready_a[k] && !fl && rst_n;
        if (acc) push(k, w);
    endtask

    task automatic drive(input int k, input logic v, input logic [IW-1:0] w, input logic ordy, input logic fl);
        bit acc;
        drive_a(k, v, w, ordy, fl, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid_a[k]  = 1'b1;
            in_ctrl_a[k]   = 3'b111;
            in_data_a[k]   = DW'(32'hDEAD_0000 + k);
            out_ready_a[k] = 1'b0;
            flush_a[k]     = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b1;
        end
    endtask

    // Monitor: compares presented outputs with the reference each cycle and retires consumed words
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rhead[k] = 0; rcnt[k] = 0; pend[k] = 1'b0; m_stall[k] = 0; last_d[k] = '0;
            end else begin
                held = rcnt[k] - (pend[k] ? 1 : 0);
                chk("out_valid", k, IW'(out_valid_a[k]), IW'(held > 0));
                chk("in_ready", k, IW'(in_ready_a[k]),
                    IW'((k == 1) ? (held < 2) : (held == 0 || out_ready_a[k] == 1'b1)));
                chk("stall_cnt", k, IW'(stall_a[k]), IW'(m_stall[k]));
                if (held > 0) begin
                    front     = rbuf[k][rhead[k]];
                    last_d[k] = front[DW-1:0];
                    chk("out_word", k, {out_ctrl_a[k], out_data_a[k]}, front);
                    if (out_ready_a[k]) begin
                        rhead[k] = (rhead[k] + 1) % 4;
                        rcnt[k]--;
                    end else if (m_stall[k] < 65535) begin
                        m_stall[k]++;
                    end
                end else begin
                    chk("bubble_ctrl", k, IW'(out_ctrl_a[k]), '0);
                    chk("bubble_data", k, IW'(out_data_a[k]), IW'(last_d[k]));
                end
                if (flush_a[k]) rcnt[k] = 0;
                pend[k] = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [IW-1:0] w;
        int            tries;

        // Reset with in_valid high: both instances come up empty and ready
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, IW'(out_valid_a[k]), '0);
            chk("rst_out_ctrl", k, IW'(out_ctrl_a[k]), '0);
            chk("rst_out_data", k, IW'(out_data_a[k]), '0);
            chk("rst_stall", k, IW'(stall_a[k]), '0);
            chk("rst_in_ready", k, IW'(in_ready_a[k]), IW'(1));
        end

        // Back-to-back stream 1..8 through the skid stage
        for (int i = 1; i <= 8; i++) begin
            w = {3'(i), DW'(i)};
            drive(1, 1'b1, w, 1'b1, 1'b0);
        end
        repeat (3) drive(1, 1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B fill the skid stage, C is held off until downstream drains
        do_reset();
        drive(1, 1'b1, {3'b001, DW'('hA)}, 1'b0, 1'b0);
        drive(1, 1'b1, {3'b010, DW'('hB)}, 1'b0, 1'b0);
        repeat (3) drive(1, 1'b1, {3'b100, DW'('hC)}, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", 1, IW'(in_ready_a[1]), '0);
        chk("bp_stall_mid", 1, IW'(stall_a[1]), IW'(3));
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 6) begin
            drive_a(1, 1'b1, {3'b100, DW'('hC)}, 1'b1, 1'b0, acc);
            tries++;
        end
        chk("bp_c_accepted", 1, IW'(acc), IW'(1));
        repeat (4) drive(1, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_stall_total", 1, IW'(stall_a[1]), IW'(4));

        // Flush in TWO with a new input offered: everything squashed, D never shows
        do_reset();
        drive(1, 1'b1, {3'b011, DW'('h1A)}, 1'b0, 1'b0);
        drive(1, 1'b1, {3'b101, DW'('h1B)}, 1'b0, 1'b0);
        drive(1, 1'b1, {3'b111, DW'('h1D)}, 1'b0, 1'b1);
        drive(1, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_out_valid", 1, IW'(out_valid_a[1]), '0);
        chk("flush_out_ctrl", 1, IW'(out_ctrl_a[1]), '0);
        // Flush in ONE with both an output and an accepted-looking input transfer
        drive(1, 1'b1, {3'b110, DW'('h2A)}, 1'b0, 1'b0);
        drive(1, 1'b1, {3'b111, DW'('h2E)}, 1'b1, 1'b1);
        repeat (3) drive(1, 1'b0, '0, 1'b1, 1'b0);

        // Single-register mode: held entry blocks input, then is replaced in one cycle
        do_reset();
        drive(0, 1'b1, {3'b001, DW'('h3A)}, 1'b0, 1'b0);
        drive(0, 1'b1, {3'b010, DW'('h3B)}, 1'b0, 1'b0);
        @(negedge clk);
        chk("s0_in_ready_low", 0, IW'(in_ready_a[0]), '0);
        drive_a(0, 1'b1, {3'b010, DW'('h3B)}, 1'b1, 1'b0, acc);
        chk("s0_replace_acc", 0, IW'(acc), IW'(1));
        repeat (3) drive(0, 1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush on both instances
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 400; i++) begin
                w = IW'({$urandom(), $urandom(), $urandom()});
                drive(k, 1'($urandom_range(0, 99) < 70), w, 1'($urandom_range(0, 99) < 60),
                      1'($urandom_range(0, 99) < 4));
            end
            repeat (4) drive(k, 1'b0, '0, 1'b1, 1'b0);
        end

        // Saturation: hold one word against a stalled consumer past 65535 cycles
        do_reset();
        drive(1, 1'b1, {3'b101, DW'('h55)}, 1'b0, 1'b0);
        repeat (70000) drive(1, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_reached", 1, IW'(stall_a[1]), IW'(16'hFFFF));
        repeat (20) drive(1, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_held", 1, IW'(stall_a[1]), IW'(16'hFFFF));
        repeat (3) drive(1, 1'b0, '0, 1'b1, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 70, SHALL set the datapath payload width (EX/MEM use: alu_result 32 + write_data 32 + write_reg 5 + upper 1).
REQ-002 Parameter CTRL_W, default 3, SHALL set the control payload width (EX/MEM use: reg_write, mem_to_reg, mem_write).
REQ-003 Parameter SKID, default 1, SHALL select the stage mode: 1 = two-entry skid buffer, 0 = single register.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate the upstream stage presents a valid instruction.
REQ-007 in_ready  output  1  SHALL indicate the stage accepts the input this cycle.
REQ-008 in_ctrl  input  CTRL_W  SHALL carry the upstream control bits.
REQ-009 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-010 out_valid  output  1  SHALL indicate the downstream stage is presented a valid instruction.
REQ-011 out_ready  input  1  SHALL indicate the downstream stage consumes the output this cycle.
REQ-012 out_ctrl  output  CTRL_W  SHALL carry the registered control bits.
REQ-013 out_data  output  DATA_W  SHALL carry the registered payload.
REQ-014 flush  input  1  SHALL squash all held and incoming instructions.
REQ-015 stall_cnt  output  16  SHALL count cycles with out_valid=1 and out_ready=0.

Function
REQ-016 A transfer SHALL occur on an interface when valid and ready are both 1 at a rising edge.
REQ-017 Every field of in_ctrl and in_data SHALL be captured together; no field is left unregistered.
REQ-018 Latency from input transfer to out_valid SHALL be exactly one cycle when the stage is empty.
REQ-019 out_ctrl SHALL be forced to all-zero whenever out_valid=0, so a bubble never asserts a write enable.
REQ-020 out_data SHALL hold its last value when out_valid=0 (no clear on the data path).
REQ-021 SKID=1: state SHALL be one of EMPTY, ONE, TWO, with in_ready = (state != TWO), driven from a register only.
REQ-022 SKID=1 transitions: EMPTY->ONE on input transfer; ONE->TWO on input transfer without output transfer; ONE->EMPTY on output transfer without input transfer; ONE->ONE on both or neither; TWO->ONE on output transfer; TWO->TWO otherwise.
REQ-023 SKID=1: in TWO, the skid entry SHALL move to the output entry on an output transfer, preserving order.
REQ-024 SKID=0: in_ready SHALL equal out_ready OR NOT out_valid (combinational), and a simultaneous input and output transfer SHALL replace the held entry.
REQ-025 flush=1 SHALL set the state to EMPTY (out_valid=0) on the next edge, with priority over any same-cycle input transfer, which is dropped.
REQ-026 An output transfer coincident with flush SHALL still count as consumed downstream.
REQ-027 stall_cnt SHALL increment by one per stalled cycle and saturate at 16'hFFFF; it SHALL not wrap.
REQ-028 in_valid=1 with in_ready=0 SHALL leave in_ctrl/in_data unsampled.

Reset
REQ-029 rst_n=0 at an edge SHALL set state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
REQ-030 Reset SHALL override flush and any transfer in the same cycle; held entries are discarded.

Structure
REQ-031 Package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, TWO), the EX/MEM default widths, and STALL_CNT_W=16.
REQ-032 One sub-module, pipe_entry (a DATA_W+CTRL_W+valid slot with load and clear), SHALL be instantiated once for SKID=0 and twice for SKID=1.

Verification
REQ-033 Reset: hold rst_n=0 two cycles, in_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1 after release.
REQ-034 Stream: SKID=1, out_ready=1, inputs data 1..8 back-to-back -> outputs 1..8 in order, one cycle delay, no bubbles.
REQ-035 Backpressure: SKID=1, send A,B,C with out_ready=0 -> in_ready falls after B, C held off; raise out_ready -> A,B,C in order, stall_cnt equals the stalled-cycle count.
REQ-036 Flush: SKID=1, state TWO, flush=1 with in_valid=1 data D -> next cycle out_valid=0, out_ctrl=0, D never appears.
REQ-037 SKID=0: out_ready=0 with one entry held -> in_ready=0; out_ready=1 with in_valid=1 -> entry replaced in one cycle.
REQ-038 Saturation: force 70000 stalled cycles -> stall_cnt=16'hFFFF and stays there.
